// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: reads a little-endian word count,
// then that many little-endian words, writing each to a word-aligned address while holding the core in reset.
module imem_loader #(
    parameter int LENGTH = 1024,
    parameter int WIDTH  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             cpu_hold,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] checksum
);

    localparam int IW = $clog2(LENGTH) + 1;

    typedef enum logic [1:0] {IDLE, LEN, DATA, DONE} state_t;

    state_t          state;
    logic [1:0]      byte_cnt;
    logic [WIDTH-1:0] shreg;
    logic [IW-1:0]   word_idx;
    logic [IW-1:0]   word_cnt;
    logic            fire;
    logic [WIDTH-1:0] word;

    assign fire = in_valid & in_ready;
    // The first byte of a word ends up in bits 7:0 after four right shifts.
    assign word = {in_data, shreg[WIDTH-1:8]};

    // in_ready is registered so it can drop in the same cycle as the final write strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            byte_cnt  <= 2'd0;
            shreg     <= '0;
            word_idx  <= '0;
            word_cnt  <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            checksum  <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= LEN;
                        byte_cnt <= 2'd0;
                        word_idx <= '0;
                        checksum <= '0;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        in_ready <= 1'b1;
                        cpu_hold <= 1'b1;
                    end
                end
                LEN: begin
                    if (fire) begin
                        shreg    <= word;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (word == '0) begin
                                state    <= DONE;
                                done     <= 1'b1;
                                in_ready <= 1'b0;
                                cpu_hold <= 1'b0;
                            end else if (word > WIDTH'(LENGTH)) begin
                                state    <= DONE;
                                err      <= 1'b1;
                                in_ready <= 1'b0;
                                cpu_hold <= 1'b0;
                            end else begin
                                state    <= DATA;
                                word_cnt <= word[IW-1:0];
                            end
                        end
                    end
                end
                DATA: begin
                    // in_ready low while in DATA marks the cycle of the final write.
                    if (!in_ready) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else if (fire) begin
                        shreg    <= word;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= word;
                            mem_addr  <= WIDTH'({word_idx, 2'b00});
                            checksum  <= checksum + word;
                            word_idx  <= word_idx + IW'(1);
                            if (word_idx + IW'(1) == word_cnt) begin
                                in_ready <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
